// File: rtl/rv_fetch_aligner_pkg.sv
// -----------------------------------------------------------------------------
// rv_fetch_aligner_pkg
// Shared types and helpers for the fetch aligner and its halfword queue.
//   hword_t        : one 16-bit instruction parcel
//   hq_cnt_t       : occupancy of the 3-entry halfword queue (EMPTY..THREE)
//   hq_push_t      : push request, 0..2 halfwords, hw[0] is the lower address
//   xlen_of()      : XLEN selected by the rv64 parameter
//   is_compressed(): RVC parcel test, shared with the decompressing decoder
// -----------------------------------------------------------------------------
package rv_fetch_aligner_pkg;

   typedef logic [15:0] hword_t;
   typedef logic [1:0]  hq_cnt_t;

   localparam hq_cnt_t CNT_EMPTY = 2'd0;
   localparam hq_cnt_t CNT_ONE   = 2'd1;
   localparam hq_cnt_t CNT_TWO   = 2'd2;
   localparam hq_cnt_t CNT_THREE = 2'd3;

   typedef struct packed {
      logic [1:0]       n;   // number of halfwords pushed (0..2)
      hword_t [1:0]     hw;  // hw[0] is appended first
   } hq_push_t;

   function automatic int unsigned xlen_of(input bit rv64);
      return rv64 ? 64 : 32;
   endfunction

   // A parcel whose two low bits are not 2'b11 is a complete 16-bit instruction.
   function automatic logic is_compressed(input hword_t h);
      return h[1:0] != 2'b11;
   endfunction

endpackage

// File: rtl/rv_halfword_queue.sv
// -----------------------------------------------------------------------------
// rv_halfword_queue
// Three-entry shift queue of instruction halfwords. Each cycle it can drop
// 0..2 halfwords from the head and then append 0..2 halfwords at the tail.
// Ports:
//   clock, reset : core clock, async active-high reset (empties the queue)
//   flush_i      : discard all content at the next edge (takes priority)
//   pop_i        : halfwords removed from the head this cycle (<= count_o)
//   push_i       : halfwords appended after the pop
//   count_o      : current occupancy
//   hq0_o, hq1_o : oldest and second-oldest entries
// -----------------------------------------------------------------------------
module rv_halfword_queue
   import rv_fetch_aligner_pkg::*;
(
   input  logic      clock,
   input  logic      reset,
   input  logic      flush_i,
   input  logic [1:0] pop_i,
   input  hq_push_t  push_i,
   output hq_cnt_t   count_o,
   output hword_t    hq0_o,
   output hword_t    hq1_o
);

   hword_t [2:0] hq_q, hq_d;
   hq_cnt_t      cnt_q, cnt_d;

   hq_cnt_t      base;
   hword_t [2:0] shifted;
   hword_t [2:0] keep;
   hword_t [2:0] push_vec;
   hword_t [2:0] appended;

   always_comb begin
      // Occupancy left after the pop; new parcels land right behind it.
      base    = cnt_q - pop_i;
      shifted = hq_q >> {pop_i, 4'b0000};

      // Entries at or beyond 'base' hold stale data and must not leak in.
      case (base)
         CNT_EMPTY: keep = '0;
         CNT_ONE:   keep = 48'h0000_0000_ffff;
         CNT_TWO:   keep = 48'h0000_ffff_ffff;
         default:   keep = '1;
      endcase

      push_vec    = '0;
      push_vec[0] = (push_i.n != 2'd0) ? push_i.hw[0] : '0;
      push_vec[1] = (push_i.n == 2'd2) ? push_i.hw[1] : '0;
      appended    = push_vec << {base, 4'b0000};

      hq_d  = (shifted & keep) | appended;
      cnt_d = base + push_i.n;
      if (flush_i) begin
         cnt_d = CNT_EMPTY;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hq_q  <= '0;
         cnt_q <= CNT_EMPTY;
      end else begin
         hq_q  <= hq_d;
         cnt_q <= cnt_d;
      end
   end

   assign count_o = cnt_q;
   assign hq0_o   = hq_q[0];
   assign hq1_o   = hq_q[1];

endmodule

// File: rtl/rv_fetch_aligner.sv
// -----------------------------------------------------------------------------
// rv_fetch_aligner
// Turns a stream of 32-bit aligned fetch words into whole RVC/RV32 instructions
// with their PC. 32-bit instructions may straddle two fetch words; redirects to
// halfword-aligned targets drop the low parcel of the first word fetched.
// Ports:
//   clock, reset                  : core clock, async active-high reset
//   in_valid/in_ready/in_data     : fetch word stream, [15:0] = lower address
//   out_valid/out_ready           : instruction handshake toward the decoder
//   out_instr                     : instruction, RVC zero-extended in [31:16]
//   out_pc                        : address of out_instr
//   redirect_valid/redirect_pc    : flush and restart at redirect_pc
// -----------------------------------------------------------------------------
module rv_fetch_aligner
   import rv_fetch_aligner_pkg::*;
#(
   parameter bit          rv64     = 1'b1,
   parameter logic [63:0] RESET_PC = 64'h0,
   localparam int unsigned XLEN    = xlen_of(rv64)
)(
   input  logic            clock,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_instr,
   output logic [XLEN-1:0] out_pc,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc
);

   logic [XLEN-1:0] pc_q, pc_d;
   logic            drop_low_q, drop_low_d;

   hq_cnt_t  count;
   hword_t   hq0, hq1;
   logic     hq0_c;
   logic     fire;
   logic [1:0] consumed;
   logic     push_fire;
   hq_push_t push;

   rv_halfword_queue u_hq (
      .clock   (clock),
      .reset   (reset),
      .flush_i (redirect_valid),
      .pop_i   (consumed),
      .push_i  (push),
      .count_o (count),
      .hq0_o   (hq0),
      .hq1_o   (hq1)
   );

   assign hq0_c = is_compressed(hq0);

   // Only registered queue state feeds the output side; in_data never reaches
   // out_instr in the same cycle.
   assign out_valid = !redirect_valid &&
                      ((count >= CNT_TWO) || (count == CNT_ONE && hq0_c));
   assign out_instr = out_valid ? (hq0_c ? {16'h0000, hq0} : {hq1, hq0}) : 'x;
   assign out_pc    = pc_q;

   assign fire     = out_valid && out_ready;
   assign consumed = fire ? (hq0_c ? 2'd1 : 2'd2) : 2'd0;

   // Room for a full word exists once at most one parcel remains after this
   // cycle's consume, so the queue never exceeds three entries.
   assign in_ready  = !redirect_valid && ((count - consumed) <= 2'd1);
   assign push_fire = in_valid && in_ready;

   always_comb begin
      push.n     = 2'd0;
      push.hw[0] = in_data[15:0];
      push.hw[1] = in_data[31:16];
      if (push_fire) begin
         if (drop_low_q) begin
            push.n     = 2'd1;
            push.hw[0] = in_data[31:16];
         end else begin
            push.n     = 2'd2;
         end
      end
   end

   always_comb begin
      pc_d       = pc_q + {{(XLEN-3){1'b0}}, consumed, 1'b0};
      drop_low_d = drop_low_q && !push_fire;
      if (redirect_valid) begin
         pc_d       = {redirect_pc[XLEN-1:1], 1'b0};
         drop_low_d = redirect_pc[1];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_q       <= {RESET_PC[XLEN-1:1], 1'b0};
         drop_low_q <= RESET_PC[1];
      end else begin
         pc_q       <= pc_d;
         drop_low_q <= drop_low_d;
      end
   end

endmodule

// File: tb/tb_rv_fetch_aligner.sv
module tb_rv_fetch_aligner;

   localparam logic [63:0] RPC = 64'h1000;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [63:0] out_pc;
   logic        redirect_valid;
   logic [63:0] redirect_pc;

   int checks = 0;
   int errors = 0;

   // Reference model: the instruction byte stream as a list of parcels.
   logic [15:0] mq[$];
   logic [63:0] mpc;
   bit          mdrop;

   always #5 clock = ~clock;

   rv_fetch_aligner #(.rv64(1'b1), .RESET_PC(RPC)) dut (
      .clock          (clock),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   function automatic bit rvc(input logic [15:0] h);
      return h[1:0] != 2'b11;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      mpc   = RPC & ~64'h1;
      mdrop = RPC[1];
   endtask

   // Check current outputs against the model, advance the model by the
   // current inputs, then move to just after the next rising edge.
   task automatic step();
      bit          ev, er;
      int          ncons;
      logic [31:0] ei;
      #1;
      ev = !redirect_valid && (mq.size() >= 2 || (mq.size() == 1 && rvc(mq[0])));
      ei = '0;
      ncons = 0;
      if (ev) begin
         ei = rvc(mq[0]) ? {16'h0000, mq[0]} : {mq[1], mq[0]};
         if (out_ready) ncons = rvc(mq[0]) ? 1 : 2;
      end
      er = !redirect_valid && (mq.size() - ncons) <= 1;
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("in_ready", 64'(in_ready), 64'(er));
      if (ev) begin
         chk("out_instr", 64'(out_instr), 64'(ei));
         chk("out_pc", out_pc, mpc);
      end
      if (redirect_valid) begin
         mq.delete();
         mpc   = redirect_pc & ~64'h1;
         mdrop = redirect_pc[1];
      end else begin
         for (int k = 0; k < ncons; k++) void'(mq.pop_front());
         mpc = mpc + 64'(2 * ncons);
         if (in_valid && er) begin
            if (mdrop) begin
               mq.push_back(in_data[31:16]);
               mdrop = 1'b0;
            end else begin
               mq.push_back(in_data[15:0]);
               mq.push_back(in_data[31:16]);
            end
         end
      end
      @(posedge clock);
      #2;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      redirect_valid = 1'b0;
      model_reset();
      @(posedge clock);
      #2;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      model_reset();
      #3;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clock);
      #2;
      reset = 1'b0;
      #1;
      chk("post_rst_out_valid", 64'(out_valid), 64'd0);
      chk("post_rst_pc", out_pc, 64'h1000);

      // 1: single 32-bit instruction
      out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h0013_0313; step();
      in_valid = 1'b0;
      chk("t1_instr", 64'(out_instr), 64'h0013_0313);
      chk("t1_pc", out_pc, 64'h1000);
      step();
      chk("t1_empty", 64'(out_valid), 64'd0);
      step();

      // 2: two compressed in one word
      apply_reset();
      out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h4505_0001; step();
      in_valid = 1'b0;
      chk("t2_instr0", 64'(out_instr), 64'h0000_0001);
      chk("t2_pc0", out_pc, 64'h1000);
      step();
      chk("t2_instr1", 64'(out_instr), 64'h0000_4505);
      chk("t2_pc1", out_pc, 64'h1002);
      step();
      step();

      // 3: straddling 32-bit instruction
      apply_reset();
      out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h0313_4505; step();
      in_data = 32'h4505_0013;
      chk("t3_instr0", 64'(out_instr), 64'h0000_4505);
      chk("t3_pc0", out_pc, 64'h1000);
      step();
      in_valid = 1'b0;
      chk("t3_instr1", 64'(out_instr), 64'h0013_0313);
      chk("t3_pc1", out_pc, 64'h1002);
      step();
      chk("t3_instr2", 64'(out_instr), 64'h0000_4505);
      chk("t3_pc2", out_pc, 64'h1006);
      step();
      step();

      // 4: full queue under backpressure
      apply_reset();
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h4505_0001; step();
      out_ready = 1'b1; in_data = 32'h0313_4505; step();
      out_ready = 1'b0;
      #1;
      chk("t4_full_in_ready", 64'(in_ready), 64'd0);
      chk("t4_hold_instr", 64'(out_instr), 64'h0000_4505);
      step();
      step();
      chk("t4_hold_pc", out_pc, 64'h1002);
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();

      // 5: redirect to halfword target
      apply_reset();
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h4505_0001; step();
      in_valid = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h2002;
      #1;
      chk("t5_redir_out_valid", 64'(out_valid), 64'd0);
      chk("t5_redir_in_ready", 64'(in_ready), 64'd0);
      step();
      redirect_valid = 1'b0; in_valid = 1'b1; in_data = 32'h4505_abcd; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("t5_instr", 64'(out_instr), 64'h0000_4505);
      chk("t5_pc", out_pc, 64'h2002);
      step();
      step();

      // 6: async reset mid-cycle with queued parcels
      apply_reset();
      out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h0013_0313; step();
      in_data = 32'h4505_0001; step();
      out_ready = 1'b0; in_valid = 1'b0;
      #1;
      chk("t6_pc_before", out_pc, 64'h1004);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_async_drop", 64'(out_valid), 64'd0);
      model_reset();
      @(posedge clock);
      #2;
      reset = 1'b0; out_ready = 1'b1;
      #1;
      chk("t6_pc_after", out_pc, 64'h1000);
      chk("t6_in_ready", 64'(in_ready), 64'd1);
      step();
      step();

      // PC wrap at the top of the address space
      redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE; step();
      redirect_valid = 1'b0; in_valid = 1'b1; in_data = 32'h0000_ffff; step();
      in_data = 32'h0001_0001; step();
      in_valid = 1'b0;
      chk("wrap_pc", out_pc, 64'h0);
      step();
      step();

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         in_valid       = ($urandom_range(0, 3) != 0);
         in_data        = $urandom;
         out_ready      = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 15) == 0);
         redirect_pc    = {$urandom, $urandom};
         step();
      end
      in_valid = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
